// File: rtl/axi_slice_pkg.sv
// Shared types and payload-width helpers for the AXI register slice.
// Widths are derived from the three AXI width parameters.
package axi_slice_pkg;

    typedef enum logic [1:0] {
        SLICE_BYPASS = 2'd0,
        SLICE_SKID   = 2'd1,
        SLICE_FWD    = 2'd2
    } slice_mode_e;

    typedef enum logic [1:0] {
        SKID_EMPTY = 2'd0,
        SKID_ONE   = 2'd1,
        SKID_TWO   = 2'd2
    } skid_state_e;

    localparam int unsigned PROT_W  = 32'd3;
    localparam int unsigned LEN_W   = 32'd8;
    localparam int unsigned SIZE_W  = 32'd3;
    localparam int unsigned BURST_W = 32'd2;
    localparam int unsigned LOCK_W  = 32'd1;
    localparam int unsigned CACHE_W = 32'd4;
    localparam int unsigned RESP_W  = 32'd2;

    function automatic int unsigned ax_width(input int unsigned addr_w, input int unsigned id_w);
        return addr_w + PROT_W + LEN_W + SIZE_W + BURST_W + LOCK_W + CACHE_W + id_w;
    endfunction

    function automatic int unsigned w_width(input int unsigned data_w);
        return data_w + (data_w / 32'd8) + 32'd1;
    endfunction

    function automatic int unsigned b_width(input int unsigned id_w);
        return RESP_W + id_w;
    endfunction

    function automatic int unsigned r_width(input int unsigned data_w, input int unsigned id_w);
        return data_w + RESP_W + 32'd1 + id_w;
    endfunction

endpackage

// File: rtl/axi_bus.sv
// AXI4 bus bundle (no user signals) with master and slave views.
interface AXI_BUS #(
    parameter int unsigned AXI_ADDR_WIDTH = 32'd32,
    parameter int unsigned AXI_DATA_WIDTH = 32'd64,
    parameter int unsigned AXI_ID_WIDTH   = 32'd8
);

    logic [AXI_ADDR_WIDTH-1:0]   aw_addr;
    logic [2:0]                  aw_prot;
    logic [7:0]                  aw_len;
    logic [2:0]                  aw_size;
    logic [1:0]                  aw_burst;
    logic                        aw_lock;
    logic [3:0]                  aw_cache;
    logic [AXI_ID_WIDTH-1:0]     aw_id;
    logic                        aw_valid;
    logic                        aw_ready;

    logic [AXI_DATA_WIDTH-1:0]   w_data;
    logic [AXI_DATA_WIDTH/8-1:0] w_strb;
    logic                        w_last;
    logic                        w_valid;
    logic                        w_ready;

    logic [1:0]                  b_resp;
    logic [AXI_ID_WIDTH-1:0]     b_id;
    logic                        b_valid;
    logic                        b_ready;

    logic [AXI_ADDR_WIDTH-1:0]   ar_addr;
    logic [2:0]                  ar_prot;
    logic [7:0]                  ar_len;
    logic [2:0]                  ar_size;
    logic [1:0]                  ar_burst;
    logic                        ar_lock;
    logic [3:0]                  ar_cache;
    logic [AXI_ID_WIDTH-1:0]     ar_id;
    logic                        ar_valid;
    logic                        ar_ready;

    logic [AXI_DATA_WIDTH-1:0]   r_data;
    logic [1:0]                  r_resp;
    logic                        r_last;
    logic [AXI_ID_WIDTH-1:0]     r_id;
    logic                        r_valid;
    logic                        r_ready;

    modport Master (
        output aw_addr, aw_prot, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_id, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_resp, b_id, b_valid,
        output b_ready,
        output ar_addr, ar_prot, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_id, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_id, r_valid,
        output r_ready
    );

    modport Slave (
        input  aw_addr, aw_prot, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_id, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_resp, b_id, b_valid,
        input  b_ready,
        input  ar_addr, ar_prot, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_id, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_id, r_valid,
        input  r_ready
    );

endinterface

// File: rtl/axi_skid_slice.sv
// One valid/ready pipeline stage: bypass, 2-entry skid buffer, or forward-only register.
// Only the state is reset; payload registers hold whatever they last loaded.
module axi_skid_slice
    import axi_slice_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd8,
    parameter int unsigned MODE  = 32'd1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (MODE == 32'(SLICE_BYPASS)) begin : g_bypass
            assign out_data  = in_data;
            assign out_valid = in_valid;
            assign in_ready  = out_ready;
        end else if (MODE == 32'(SLICE_SKID)) begin : g_skid
            skid_state_e      state_r;
            skid_state_e      state_nxt_s;
            logic [WIDTH-1:0] out_data_r;
            logic [WIDTH-1:0] skid_data_r;
            logic             push_s;
            logic             pop_s;
            logic             load_out_s;
            logic             load_skid_s;
            logic             shift_skid_s;

            // in_ready depends only on state and reset, never on out_ready
            assign in_ready  = (state_r != SKID_TWO) && !rst_i;
            assign out_valid = (state_r != SKID_EMPTY);
            assign out_data  = out_data_r;
            assign push_s    = in_valid && in_ready;
            assign pop_s     = out_valid && out_ready;

            // Occupancy state register
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_r <= SKID_EMPTY;
                end else begin
                    state_r <= state_nxt_s;
                end
            end

            // Next-state and payload-register load decode
            always_comb begin
                state_nxt_s  = state_r;
                load_out_s   = 1'b0;
                load_skid_s  = 1'b0;
                shift_skid_s = 1'b0;
                case (state_r)
                    SKID_EMPTY: begin
                        if (push_s) begin
                            state_nxt_s = SKID_ONE;
                            load_out_s  = 1'b1;
                        end else begin
                            state_nxt_s = SKID_EMPTY;
                        end
                    end
                    SKID_ONE: begin
                        if (push_s && !pop_s) begin
                            state_nxt_s = SKID_TWO;
                            load_skid_s = 1'b1;
                        end else if (push_s && pop_s) begin
                            state_nxt_s = SKID_ONE;
                            load_out_s  = 1'b1;
                        end else if (pop_s) begin
                            state_nxt_s = SKID_EMPTY;
                        end else begin
                            state_nxt_s = SKID_ONE;
                        end
                    end
                    SKID_TWO: begin
                        if (pop_s) begin
                            state_nxt_s  = SKID_ONE;
                            shift_skid_s = 1'b1;
                        end else begin
                            state_nxt_s = SKID_TWO;
                        end
                    end
                    default: begin
                        state_nxt_s = SKID_EMPTY;
                    end
                endcase
            end

            // Output and skid payload registers
            always_ff @(posedge clk_i) begin
                if (load_out_s) begin
                    out_data_r <= in_data;
                end else if (shift_skid_s) begin
                    out_data_r <= skid_data_r;
                end else begin
                    out_data_r <= out_data_r;
                end
                if (load_skid_s) begin
                    skid_data_r <= in_data;
                end else begin
                    skid_data_r <= skid_data_r;
                end
            end
        end else if (MODE == 32'(SLICE_FWD)) begin : g_fwd
            logic             valid_r;
            logic [WIDTH-1:0] data_r;
            logic             push_s;

            assign in_ready  = (!valid_r || out_ready) && !rst_i;
            assign out_valid = valid_r;
            assign out_data  = data_r;
            assign push_s    = in_valid && in_ready;

            // Output valid flag
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_r <= 1'b0;
                end else if (push_s) begin
                    valid_r <= 1'b1;
                end else if (out_ready) begin
                    valid_r <= 1'b0;
                end else begin
                    valid_r <= valid_r;
                end
            end

            // Output payload register
            always_ff @(posedge clk_i) begin
                if (push_s) begin
                    data_r <= in_data;
                end else begin
                    data_r <= data_r;
                end
            end
        end else begin : g_bad_mode
            $error("axi_skid_slice: unsupported MODE %0d", MODE);
        end
    endgenerate

endmodule

// File: rtl/axi_reg_slice.sv
// AXI4 register slice: one independently configured stage per channel.
// AW/W/AR flow slv->mst, B/R flow mst->slv; payload bits pass through unmodified.
module axi_reg_slice
    import axi_slice_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 32'd32,
    parameter int unsigned AXI_DATA_WIDTH = 32'd64,
    parameter int unsigned AXI_ID_WIDTH   = 32'd8,
    parameter int unsigned AW_MODE        = 32'd1,
    parameter int unsigned W_MODE         = 32'd1,
    parameter int unsigned B_MODE         = 32'd1,
    parameter int unsigned AR_MODE        = 32'd1,
    parameter int unsigned R_MODE         = 32'd1
) (
    input  logic  clk_i,
    input  logic  rst_i,
    AXI_BUS.Slave  slv,
    AXI_BUS.Master mst
);

    localparam int unsigned AX_W = ax_width(AXI_ADDR_WIDTH, AXI_ID_WIDTH);
    localparam int unsigned W_W  = w_width(AXI_DATA_WIDTH);
    localparam int unsigned B_W  = b_width(AXI_ID_WIDTH);
    localparam int unsigned R_W  = r_width(AXI_DATA_WIDTH, AXI_ID_WIDTH);

    logic [AX_W-1:0] aw_in_s;
    logic [AX_W-1:0] aw_out_s;
    logic [W_W-1:0]  w_in_s;
    logic [W_W-1:0]  w_out_s;
    logic [B_W-1:0]  b_in_s;
    logic [B_W-1:0]  b_out_s;
    logic [AX_W-1:0] ar_in_s;
    logic [AX_W-1:0] ar_out_s;
    logic [R_W-1:0]  r_in_s;
    logic [R_W-1:0]  r_out_s;

    assign aw_in_s = {slv.aw_addr, slv.aw_prot, slv.aw_len, slv.aw_size,
                      slv.aw_burst, slv.aw_lock, slv.aw_cache, slv.aw_id};
    assign {mst.aw_addr, mst.aw_prot, mst.aw_len, mst.aw_size,
            mst.aw_burst, mst.aw_lock, mst.aw_cache, mst.aw_id} = aw_out_s;

    assign w_in_s = {slv.w_data, slv.w_strb, slv.w_last};
    assign {mst.w_data, mst.w_strb, mst.w_last} = w_out_s;

    assign b_in_s = {mst.b_resp, mst.b_id};
    assign {slv.b_resp, slv.b_id} = b_out_s;

    assign ar_in_s = {slv.ar_addr, slv.ar_prot, slv.ar_len, slv.ar_size,
                      slv.ar_burst, slv.ar_lock, slv.ar_cache, slv.ar_id};
    assign {mst.ar_addr, mst.ar_prot, mst.ar_len, mst.ar_size,
            mst.ar_burst, mst.ar_lock, mst.ar_cache, mst.ar_id} = ar_out_s;

    assign r_in_s = {mst.r_data, mst.r_resp, mst.r_last, mst.r_id};
    assign {slv.r_data, slv.r_resp, slv.r_last, slv.r_id} = r_out_s;

    axi_skid_slice #(.WIDTH(AX_W), .MODE(AW_MODE)) u_aw (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_data   (aw_in_s),
        .in_valid  (slv.aw_valid),
        .in_ready  (slv.aw_ready),
        .out_data  (aw_out_s),
        .out_valid (mst.aw_valid),
        .out_ready (mst.aw_ready)
    );

    axi_skid_slice #(.WIDTH(W_W), .MODE(W_MODE)) u_w (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_data   (w_in_s),
        .in_valid  (slv.w_valid),
        .in_ready  (slv.w_ready),
        .out_data  (w_out_s),
        .out_valid (mst.w_valid),
        .out_ready (mst.w_ready)
    );

    axi_skid_slice #(.WIDTH(B_W), .MODE(B_MODE)) u_b (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_data   (b_in_s),
        .in_valid  (mst.b_valid),
        .in_ready  (mst.b_ready),
        .out_data  (b_out_s),
        .out_valid (slv.b_valid),
        .out_ready (slv.b_ready)
    );

    axi_skid_slice #(.WIDTH(AX_W), .MODE(AR_MODE)) u_ar (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_data   (ar_in_s),
        .in_valid  (slv.ar_valid),
        .in_ready  (slv.ar_ready),
        .out_data  (ar_out_s),
        .out_valid (mst.ar_valid),
        .out_ready (mst.ar_ready)
    );

    axi_skid_slice #(.WIDTH(R_W), .MODE(R_MODE)) u_r (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .in_data   (r_in_s),
        .in_valid  (mst.r_valid),
        .in_ready  (mst.r_ready),
        .out_data  (r_out_s),
        .out_valid (slv.r_valid),
        .out_ready (slv.r_ready)
    );

endmodule

// File: tb/tb_axi_reg_slice.sv
// Directed bench for axi_reg_slice with AW bypass, W/B/AR skid and R forward-only stages.
module tb_axi_reg_slice;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   sent;
    int   rcv;
    logic [3:0] rdy_pat;

    AXI_BUS #(.AXI_ADDR_WIDTH(32'd32), .AXI_DATA_WIDTH(32'd64), .AXI_ID_WIDTH(32'd8)) slv_bus ();
    AXI_BUS #(.AXI_ADDR_WIDTH(32'd32), .AXI_DATA_WIDTH(32'd64), .AXI_ID_WIDTH(32'd8)) mst_bus ();

    axi_reg_slice #(
        .AXI_ADDR_WIDTH (32'd32),
        .AXI_DATA_WIDTH (32'd64),
        .AXI_ID_WIDTH   (32'd8),
        .AW_MODE        (32'd0),
        .W_MODE         (32'd1),
        .B_MODE         (32'd1),
        .AR_MODE        (32'd1),
        .R_MODE         (32'd2)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .slv   (slv_bus),
        .mst   (mst_bus)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus and checks
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        slv_bus.aw_addr = 32'h0; slv_bus.aw_prot = 3'd0; slv_bus.aw_len = 8'd0; slv_bus.aw_size = 3'd0;
        slv_bus.aw_burst = 2'd0; slv_bus.aw_lock = 1'b0; slv_bus.aw_cache = 4'd0; slv_bus.aw_id = 8'd0;
        slv_bus.aw_valid = 1'b0;
        slv_bus.w_data = 64'h0; slv_bus.w_strb = 8'hFF; slv_bus.w_last = 1'b0; slv_bus.w_valid = 1'b0;
        slv_bus.b_ready = 1'b0;
        slv_bus.ar_addr = 32'h0; slv_bus.ar_prot = 3'd0; slv_bus.ar_len = 8'd0; slv_bus.ar_size = 3'd0;
        slv_bus.ar_burst = 2'd0; slv_bus.ar_lock = 1'b0; slv_bus.ar_cache = 4'd0; slv_bus.ar_id = 8'd0;
        slv_bus.ar_valid = 1'b0;
        slv_bus.r_ready = 1'b0;
        mst_bus.aw_ready = 1'b0; mst_bus.w_ready = 1'b0; mst_bus.ar_ready = 1'b0;
        mst_bus.b_resp = 2'd0; mst_bus.b_id = 8'd0; mst_bus.b_valid = 1'b0;
        mst_bus.r_data = 64'h0; mst_bus.r_resp = 2'd0; mst_bus.r_last = 1'b0; mst_bus.r_id = 8'd0;
        mst_bus.r_valid = 1'b0;

        // Reset held 3 cycles with an AR request pending
        tick();
        slv_bus.ar_valid = 1'b1;
        slv_bus.ar_id    = 8'h55;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rst_mst_ar_valid", mst_bus.ar_valid, 64'd0);
            check_eq("rst_slv_ar_ready", slv_bus.ar_ready, 64'd0);
            check_eq("rst_slv_w_ready", slv_bus.w_ready, 64'd0);
            check_eq("rst_mst_r_ready", mst_bus.r_ready, 64'd0);
            check_eq("rst_mst_b_ready", mst_bus.b_ready, 64'd0);
            tick();
        end
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_slv_ar_ready", slv_bus.ar_ready, 64'd1);
        check_eq("rel_mst_ar_valid", mst_bus.ar_valid, 64'd0);
        tick();
        slv_bus.ar_valid = 1'b0;
        mst_bus.ar_ready = 1'b1;
        @(negedge clk);
        check_eq("rel_ar_lat_valid", mst_bus.ar_valid, 64'd1);
        check_eq("rel_ar_lat_id", mst_bus.ar_id, 64'h55);
        tick();
        @(negedge clk);
        check_eq("rel_ar_drained", mst_bus.ar_valid, 64'd0);

        // AR streaming: 16 back-to-back beats, consumer always ready
        for (int k = 0; k < 16; k++) begin
            tick();
            slv_bus.ar_valid = 1'b1;
            slv_bus.ar_id    = 8'(k);
            slv_bus.ar_addr  = 32'h1000_0000 + 32'(k);
            @(negedge clk);
            check_eq("strm_ar_ready", slv_bus.ar_ready, 64'd1);
            check_eq("strm_ar_valid", mst_bus.ar_valid, (k > 0) ? 64'd1 : 64'd0);
            if (k > 0) begin
                check_eq("strm_ar_id", mst_bus.ar_id, 64'(k - 1));
                check_eq("strm_ar_addr", mst_bus.ar_addr, 64'h1000_0000 + 64'(k - 1));
            end
        end
        tick();
        slv_bus.ar_valid = 1'b0;
        @(negedge clk);
        check_eq("strm_ar_last_valid", mst_bus.ar_valid, 64'd1);
        check_eq("strm_ar_last_id", mst_bus.ar_id, 64'd15);
        tick();
        @(negedge clk);
        check_eq("strm_ar_idle", mst_bus.ar_valid, 64'd0);

        // W backpressure: 4 beats, consumer stalled for 5 cycles
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            slv_bus.w_valid  = (sent < 4);
            slv_bus.w_data   = 64'hA0 + 64'(sent);
            slv_bus.w_last   = (sent == 3);
            mst_bus.w_ready  = (c >= 5);
            @(negedge clk);
            if (c == 2) begin
                check_eq("bp_w_ready_full", slv_bus.w_ready, 64'd0);
                check_eq("bp_w_accepted", 64'(sent), 64'd2);
            end
            if (c >= 1 && c < 5) begin
                check_eq("bp_w_valid_hold", mst_bus.w_valid, 64'd1);
                check_eq("bp_w_data_stable", mst_bus.w_data, 64'hA0);
            end
            if (mst_bus.w_valid && mst_bus.w_ready) begin
                check_eq("bp_w_data", mst_bus.w_data, 64'hA0 + 64'(rcv));
                check_eq("bp_w_last", mst_bus.w_last, (rcv == 3) ? 64'd1 : 64'd0);
                rcv++;
            end
            if (slv_bus.w_valid && slv_bus.w_ready) begin
                sent++;
            end
        end
        check_eq("bp_w_total_rcv", 64'(rcv), 64'd4);
        check_eq("bp_w_total_sent", 64'(sent), 64'd4);

        // AR push+pop with out_ready pattern 1,1,0,1
        rdy_pat = 4'b1011;
        sent = 0;
        rcv  = 0;
        for (int c = 0; c < 30; c++) begin
            tick();
            slv_bus.ar_valid = (sent < 8);
            slv_bus.ar_id    = 8'h20 + 8'(sent);
            mst_bus.ar_ready = rdy_pat[c % 4];
            @(negedge clk);
            if (mst_bus.ar_valid && mst_bus.ar_ready) begin
                check_eq("pp_ar_id", mst_bus.ar_id, 64'h20 + 64'(rcv));
                rcv++;
            end
            if (slv_bus.ar_valid && slv_bus.ar_ready) begin
                sent++;
            end
            check_eq("pp_occupancy_le2", 64'((sent - rcv) <= 2), 64'd1);
        end
        check_eq("pp_ar_total", 64'(rcv), 64'd8);
        tick();
        slv_bus.ar_valid = 1'b0;
        mst_bus.ar_ready = 1'b1;

        // AW bypass: combinational in the same cycle
        slv_bus.aw_valid = 1'b1;
        slv_bus.aw_addr  = 32'hDEAD_BEE0;
        slv_bus.aw_id    = 8'h3C;
        mst_bus.aw_ready = 1'b0;
        #1;
        check_eq("byp_aw_valid", mst_bus.aw_valid, 64'd1);
        check_eq("byp_aw_addr", mst_bus.aw_addr, 64'hDEAD_BEE0);
        check_eq("byp_aw_id", mst_bus.aw_id, 64'h3C);
        check_eq("byp_aw_ready_lo", slv_bus.aw_ready, 64'd0);
        mst_bus.aw_ready = 1'b1;
        #1;
        check_eq("byp_aw_ready_hi", slv_bus.aw_ready, 64'd1);
        slv_bus.aw_valid = 1'b0;

        // R forward-only: one cycle latency, ready = !valid | out_ready
        mst_bus.r_valid = 1'b1;
        mst_bus.r_data  = 64'h1234_5678_9ABC_DEF0;
        mst_bus.r_id    = 8'h07;
        mst_bus.r_resp  = 2'b10;
        mst_bus.r_last  = 1'b1;
        slv_bus.r_ready = 1'b0;
        @(negedge clk);
        check_eq("fwd_r_valid_pre", slv_bus.r_valid, 64'd0);
        check_eq("fwd_r_ready_empty", mst_bus.r_ready, 64'd1);
        tick();
        mst_bus.r_valid = 1'b0;
        @(negedge clk);
        check_eq("fwd_r_valid", slv_bus.r_valid, 64'd1);
        check_eq("fwd_r_data", slv_bus.r_data, 64'h1234_5678_9ABC_DEF0);
        check_eq("fwd_r_id", slv_bus.r_id, 64'h07);
        check_eq("fwd_r_resp", slv_bus.r_resp, 64'd2);
        check_eq("fwd_r_last", slv_bus.r_last, 64'd1);
        check_eq("fwd_r_ready_full", mst_bus.r_ready, 64'd0);
        slv_bus.r_ready = 1'b1;
        #1;
        check_eq("fwd_r_ready_follow", mst_bus.r_ready, 64'd1);
        tick();
        @(negedge clk);
        check_eq("fwd_r_drained", slv_bus.r_valid, 64'd0);

        // B skid: one beat, latency 1
        tick();
        mst_bus.b_valid = 1'b1;
        mst_bus.b_resp  = 2'b01;
        mst_bus.b_id    = 8'h09;
        slv_bus.b_ready = 1'b1;
        @(negedge clk);
        check_eq("b_valid_pre", slv_bus.b_valid, 64'd0);
        tick();
        mst_bus.b_valid = 1'b0;
        @(negedge clk);
        check_eq("b_valid", slv_bus.b_valid, 64'd1);
        check_eq("b_payload", {slv_bus.b_resp, slv_bus.b_id}, 64'h109);

        // Reset with W holding two beats
        tick();
        mst_bus.w_ready = 1'b0;
        slv_bus.w_valid = 1'b1;
        slv_bus.w_data  = 64'hB0;
        slv_bus.w_last  = 1'b0;
        tick();
        slv_bus.w_data  = 64'hB1;
        tick();
        slv_bus.w_valid = 1'b0;
        @(negedge clk);
        check_eq("mr_w_ready_full", slv_bus.w_ready, 64'd0);
        check_eq("mr_w_valid_full", mst_bus.w_valid, 64'd1);
        tick();
        rst = 1'b1;
        tick();
        @(negedge clk);
        check_eq("mr_w_valid_rst", mst_bus.w_valid, 64'd0);
        check_eq("mr_w_ready_rst", slv_bus.w_ready, 64'd0);
        tick();
        rst = 1'b0;
        mst_bus.w_ready = 1'b1;
        @(negedge clk);
        check_eq("mr_w_ready_rel", slv_bus.w_ready, 64'd1);
        for (int i = 0; i < 4; i++) begin
            check_eq("mr_no_stale", mst_bus.w_valid, 64'd0);
            tick();
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_reg_slice.md
Name: axi_reg_slice

Overview:
- Parametrised AXI4 register slice: one independently configurable pipeline stage on each of the five channels (AW, W, B, AR, R), between an upstream AXI_BUS.Master and a downstream AXI_BUS.Slave.
- Used at interconnect boundaries (core to xbar, xbar to DDR/peripheral bridges) to break timing paths without losing throughput.
- Adds per-channel modes, generic widths, and registered handshakes with 2-entry skid buffering.

Parameters:
- AXI_ADDR_WIDTH, 32, address width of AW/AR.
- AXI_DATA_WIDTH, 64, data width of W/R; strobe width = AXI_DATA_WIDTH/8.
- AXI_ID_WIDTH, 8, ID width of AW/AR/B/R.
- AW_MODE, 1, AW channel mode: 0 bypass, 1 full skid (2-entry), 2 forward-only (1-entry).
- W_MODE, 1, W channel mode (encoding as AW_MODE).
- B_MODE, 1, B channel mode.
- AR_MODE, 1, AR channel mode.
- R_MODE, 1, R channel mode.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- slv  AXI_BUS.Slave  (iface)  upstream side; receives AW/W/AR, returns B/R.
- mst  AXI_BUS.Master  (iface)  downstream side; drives AW/W/AR, receives B/R.

Behaviour:
- Channel payloads:
  - AW/AR = {addr, prot, len, size, burst, lock, cache, id}.
  - W = {data, strb, last}.
  - R = {data, resp, last, id}.
  - B = {resp, id}.
- Forward direction: AW/W/AR go slv->mst. Reverse direction: B/R go mst->slv.
- Each channel is an in/out valid-ready pair: in_valid/in_ready on the producer side, out_valid/out_ready on the consumer side.
- Mode 0 (bypass): pure wires; out=in, in_ready=out_ready; zero latency; no state.
- Mode 1 (full skid): states EMPTY, ONE, TWO.
  - out_valid = (state != EMPTY).
  - in_ready = (state != TWO) and not rst_i; registered, no combinational path from out_ready.
  - Transitions, with push = in_valid & in_ready and pop = out_valid & out_ready:
    - EMPTY: push -> ONE.
    - ONE: push&!pop -> TWO; !push&pop -> EMPTY; push&pop -> ONE (new beat replaces old).
    - TWO: pop -> ONE (skid entry moves to output register); push impossible.
  - Latency 1 cycle from push to out_valid; sustained throughput 1 beat/cycle with out_ready held high.
- Mode 2 (forward-only): one output register.
  - in_ready = !out_valid | out_ready (combinational from out_ready).
  - push loads register; latency 1; full throughput; breaks only the valid/data path.
- Ordering: strict FIFO per channel; no reordering, merging or dropping; payload bits unmodified.
- Reset:
  - While rst_i high: all out_valid = 0 and all in_ready = 0 in modes 1/2.
  - Cycle after rst_i falls: in_ready = 1.
  - Data registers are not reset; state only.
- Reset mid-operation: buffered beats are discarded; out_valid = 0 on the cycle rst_i is sampled high.
- out_valid must never drop without a pop; payload stable while out_valid & !out_ready (AXI rule).
- Independent channels: no cross-channel coupling; W may lead or lag AW.
- Illegal MODE value (>2): elaboration-time $error.

Decomposition:
- Package axi_slice_pkg:
  - slice_mode_e enum {SLICE_BYPASS=0, SLICE_SKID=1, SLICE_FWD=2}.
  - Width functions for AW/W/B/AR/R payloads from the three AXI width parameters.
- Sub-module axi_skid_slice (params WIDTH, MODE): one generic channel stage.
  - axi_reg_slice instantiates five of these and packs/unpacks the interface signals into flat payload vectors.

Test Plan:
- Reset: rst_i high 3 cycles with slv.ar_valid=1 -> mst.ar_valid=0 and slv.ar_ready=0 throughout; slv.ar_ready=1 on first cycle after release.
- Streaming, mode 1: 16 AR beats, ids 0..15, back-to-back, mst.ar_ready=1 -> mst.ar_valid first high 1 cycle after first push; 16 consecutive cycles, ids in order.
- Backpressure, W mode 1: push 4 beats (data 0xA0..0xA3, last on 4th) with mst.w_ready=0 for 5 cycles -> slv.w_ready low after 2 accepted; after release all 4 beats delivered in order, w_last only on 0xA3, payload stable while stalled.
- Push+pop in ONE: steady 1 beat/cycle with out_ready toggling 1,1,0,1 -> no lost or duplicated beat, occupancy never exceeds 2.
- Mixed modes: AW_MODE=0, R_MODE=2 -> AW appears same cycle (combinational); R appears 1 cycle later; slv.r_ready follows mst rule !valid|ready.
- Reset mid-operation: assert rst_i with W slice in TWO -> mst.w_valid=0 next edge; no stale beat emitted after reset release.
